// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use interlock, branch flush and mul/div start/done sequencing.
// Optional performance counters are compiled in when HAZARD_PERF_CNT_EN is defined.
//
// state   | meaning
// RUN     | normal issue; branch flush, mul/div launch and load-use checks are active
// MD_WAIT | mul/div launched; pipeline is held until md_done
module hazard_ctrl #(
  parameter int REG_ADDR_WIDTH = 5
`ifdef HAZARD_PERF_CNT_EN
  ,
  parameter int CNT_WIDTH = 32
`endif
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_addr_id,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_addr_id,
  input  logic                      rs1_used_id,
  input  logic                      rs2_used_id,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_ex,
  input  logic                      mem_read_ex,
  input  logic                      branch_taken_ex,
  input  logic                      md_op_ex,
  input  logic                      md_done,
  output logic                      md_start,
  output logic                      md_busy,
  output logic                      stall_pc,
  output logic                      stall_if_id,
  output logic                      stall_id_ex,
  output logic                      flush_if_id,
  output logic                      flush_id_ex,
  output logic                      flush_ex_mem
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]      load_stall_cnt,
  output logic [CNT_WIDTH-1:0]      flush_cnt,
  output logic [CNT_WIDTH-1:0]      md_stall_cnt
`endif
);

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } state_t;

  state_t state_q, state_d;
  logic   load_use_hit;
  logic   load_stall;
  logic   br_flush;

  always_comb begin
    load_use_hit = mem_read_ex && (rd_addr_ex != '0) &&
                   ((rs1_used_id && (rs1_addr_id == rd_addr_ex)) ||
                    (rs2_used_id && (rs2_addr_id == rd_addr_ex)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    md_start     = 1'b0;
    md_busy      = 1'b0;
    stall_pc     = 1'b0;
    stall_if_id  = 1'b0;
    stall_id_ex  = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    flush_ex_mem = 1'b0;
    load_stall   = 1'b0;
    br_flush     = 1'b0;
    case (state_q)
      RUN: begin
        if (branch_taken_ex) begin
          // The ID instruction is discarded, so any load-use stall would be wasted.
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
          br_flush    = 1'b1;
        end else if (md_op_ex) begin
          md_start     = 1'b1;
          md_busy      = 1'b1;
          stall_pc     = 1'b1;
          stall_if_id  = 1'b1;
          stall_id_ex  = 1'b1;
          flush_ex_mem = 1'b1;
          state_d      = MD_WAIT;
        end else if (load_use_hit) begin
          stall_pc    = 1'b1;
          stall_if_id = 1'b1;
          flush_id_ex = 1'b1;
          load_stall  = 1'b1;
        end
      end
      MD_WAIT: begin
        if (md_done) begin
          state_d = RUN;
        end else begin
          md_busy      = 1'b1;
          stall_pc     = 1'b1;
          stall_if_id  = 1'b1;
          stall_id_ex  = 1'b1;
          flush_ex_mem = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
    // Outputs are forced low during reset without waiting for a clock edge.
    if (!rst_n) begin
      md_start     = 1'b0;
      md_busy      = 1'b0;
      stall_pc     = 1'b0;
      stall_if_id  = 1'b0;
      stall_id_ex  = 1'b0;
      flush_if_id  = 1'b0;
      flush_id_ex  = 1'b0;
      flush_ex_mem = 1'b0;
      load_stall   = 1'b0;
      br_flush     = 1'b0;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] load_stall_cnt_q, load_stall_cnt_d;
  logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_WIDTH-1:0] md_stall_cnt_q, md_stall_cnt_d;

  always_comb begin
    load_stall_cnt_d = load_stall_cnt_q + {{(CNT_WIDTH-1){1'b0}}, load_stall};
    flush_cnt_d      = flush_cnt_q + {{(CNT_WIDTH-1){1'b0}}, br_flush};
    md_stall_cnt_d   = md_stall_cnt_q + {{(CNT_WIDTH-1){1'b0}}, md_busy};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_stall_cnt_q <= '0;
      flush_cnt_q      <= '0;
      md_stall_cnt_q   <= '0;
    end else begin
      load_stall_cnt_q <= load_stall_cnt_d;
      flush_cnt_q      <= flush_cnt_d;
      md_stall_cnt_q   <= md_stall_cnt_d;
    end
  end

  assign load_stall_cnt = load_stall_cnt_q;
  assign flush_cnt      = flush_cnt_q;
  assign md_stall_cnt   = md_stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; outputs are checked combinationally mid-cycle.
// Counter checks are included when HAZARD_PERF_CNT_EN is defined.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs1_addr_id, rs2_addr_id, rd_addr_ex;
  logic       rs1_used_id, rs2_used_id, mem_read_ex, branch_taken_ex, md_op_ex, md_done;
  logic       md_start, md_busy, stall_pc, stall_if_id, stall_id_ex;
  logic       flush_if_id, flush_id_ex, flush_ex_mem;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] load_stall_cnt, flush_cnt, md_stall_cnt;
  logic [3:0]  load_stall_cnt4, flush_cnt4, md_stall_cnt4;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  // {md_start, md_busy, stall_pc, stall_if_id, stall_id_ex, flush_if_id, flush_id_ex, flush_ex_mem}
  localparam logic [7:0] O_IDLE = 8'b0000_0000;
  localparam logic [7:0] O_LOAD = 8'b0011_0010;
  localparam logic [7:0] O_BR   = 8'b0000_0110;
  localparam logic [7:0] O_MDS  = 8'b1111_1001;
  localparam logic [7:0] O_MDW  = 8'b0111_1001;

  logic [7:0] outs;
  assign outs = {md_start, md_busy, stall_pc, stall_if_id, stall_id_ex,
                 flush_if_id, flush_id_ex, flush_ex_mem};

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_ADDR_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_addr_id(rs1_addr_id), .rs2_addr_id(rs2_addr_id),
    .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
    .rd_addr_ex(rd_addr_ex), .mem_read_ex(mem_read_ex),
    .branch_taken_ex(branch_taken_ex), .md_op_ex(md_op_ex), .md_done(md_done),
    .md_start(md_start), .md_busy(md_busy), .stall_pc(stall_pc),
    .stall_if_id(stall_if_id), .stall_id_ex(stall_id_ex),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .flush_ex_mem(flush_ex_mem)
`ifdef HAZARD_PERF_CNT_EN
    , .load_stall_cnt(load_stall_cnt), .flush_cnt(flush_cnt), .md_stall_cnt(md_stall_cnt)
`endif
  );

`ifdef HAZARD_PERF_CNT_EN
  logic md_start4, md_busy4, stall_pc4, stall_if_id4, stall_id_ex4;
  logic flush_if_id4, flush_id_ex4, flush_ex_mem4;

  hazard_ctrl #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .rs1_addr_id(rs1_addr_id), .rs2_addr_id(rs2_addr_id),
    .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
    .rd_addr_ex(rd_addr_ex), .mem_read_ex(mem_read_ex),
    .branch_taken_ex(branch_taken_ex), .md_op_ex(md_op_ex), .md_done(md_done),
    .md_start(md_start4), .md_busy(md_busy4), .stall_pc(stall_pc4),
    .stall_if_id(stall_if_id4), .stall_id_ex(stall_id_ex4),
    .flush_if_id(flush_if_id4), .flush_id_ex(flush_id_ex4), .flush_ex_mem(flush_ex_mem4),
    .load_stall_cnt(load_stall_cnt4), .flush_cnt(flush_cnt4), .md_stall_cnt(md_stall_cnt4)
  );
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clr_in();
    rs1_addr_id = '0; rs2_addr_id = '0; rd_addr_ex = '0;
    rs1_used_id = 1'b0; rs2_used_id = 1'b0; mem_read_ex = 1'b0;
    branch_taken_ex = 1'b0; md_op_ex = 1'b0; md_done = 1'b0;
  endtask

  // Advance to the next negedge and clear inputs; caller then sets this cycle's inputs.
  task automatic next_cyc();
    @(negedge clk);
    clr_in();
  endtask

  task automatic load_hit(input logic [4:0] r);
    mem_read_ex = 1'b1; rd_addr_ex = r; rs2_addr_id = r; rs2_used_id = 1'b1;
  endtask

  initial begin
    clr_in();
    rst_n = 1'b0;
    load_hit(5'd5);
    #2;
    check("reset_with_hazard", {24'd0, outs}, {24'd0, O_IDLE});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    next_cyc(); #1;
    check("idle", {24'd0, outs}, {24'd0, O_IDLE});

    next_cyc(); load_hit(5'd5); #1;
    check("load_use_rs2", {24'd0, outs}, {24'd0, O_LOAD});
    next_cyc(); #1;
    check("load_use_one_cycle", {24'd0, outs}, {24'd0, O_IDLE});

    next_cyc(); load_hit(5'd5); rs2_used_id = 1'b0; #1;
    check("load_rs2_unused", {24'd0, outs}, {24'd0, O_IDLE});

    next_cyc(); mem_read_ex = 1'b1; rd_addr_ex = 5'd0; rs1_addr_id = 5'd0; rs1_used_id = 1'b1; #1;
    check("load_rd_x0", {24'd0, outs}, {24'd0, O_IDLE});

    next_cyc(); mem_read_ex = 1'b1; rd_addr_ex = 5'd12; rs1_addr_id = 5'd12; rs1_used_id = 1'b1;
    rs2_addr_id = 5'd3; rs2_used_id = 1'b1; #1;
    check("load_use_rs1", {24'd0, outs}, {24'd0, O_LOAD});

    next_cyc(); mem_read_ex = 1'b1; rd_addr_ex = 5'd12; rs1_addr_id = 5'd13; rs1_used_id = 1'b1; #1;
    check("load_no_match", {24'd0, outs}, {24'd0, O_IDLE});

    next_cyc(); load_hit(5'd7); branch_taken_ex = 1'b1; #1;
    check("branch_over_load", {24'd0, outs}, {24'd0, O_BR});

    // 4-cycle mul/div: done on cycle 3, back-to-back op on cycle 4
    next_cyc(); md_op_ex = 1'b1; #1;
    check("md_c0_start", {24'd0, outs}, {24'd0, O_MDS});
    next_cyc(); md_op_ex = 1'b1; #1;
    check("md_c1_wait", {24'd0, outs}, {24'd0, O_MDW});
    next_cyc(); md_op_ex = 1'b1; branch_taken_ex = 1'b1; #1;
    check("md_c2_branch_ignored", {24'd0, outs}, {24'd0, O_MDW});
    next_cyc(); md_op_ex = 1'b1; md_done = 1'b1; #1;
    check("md_c3_done", {24'd0, outs}, {24'd0, O_IDLE});
    next_cyc(); md_op_ex = 1'b1; #1;
    check("md_c4_b2b_start", {24'd0, outs}, {24'd0, O_MDS});
    next_cyc(); md_op_ex = 1'b1; md_done = 1'b1; #1;
    check("md_min_2cyc_done", {24'd0, outs}, {24'd0, O_IDLE});
    next_cyc(); md_done = 1'b1; #1;
    check("md_done_in_run", {24'd0, outs}, {24'd0, O_IDLE});
    next_cyc(); load_hit(5'd9); #1;
    check("run_after_done_in_run", {24'd0, outs}, {24'd0, O_LOAD});

    // Reset during MD_WAIT
    next_cyc(); md_op_ex = 1'b1; #1;
    check("rst_md_start", {24'd0, outs}, {24'd0, O_MDS});
    next_cyc(); md_op_ex = 1'b1; #1;
    check("rst_md_wait1", {24'd0, outs}, {24'd0, O_MDW});
    next_cyc(); md_op_ex = 1'b1; rst_n = 1'b0; #1;
    check("rst_mid_op", {24'd0, outs}, {24'd0, O_IDLE});
    next_cyc(); rst_n = 1'b1; #1;
    check("rst_release", {24'd0, outs}, {24'd0, O_IDLE});
    next_cyc(); #1;
    check("rst_state_run", {24'd0, outs}, {24'd0, O_IDLE});
    next_cyc(); load_hit(5'd4); #1;
    check("rst_load_in_run", {24'd0, outs}, {24'd0, O_LOAD});

`ifdef HAZARD_PERF_CNT_EN
    next_cyc(); rst_n = 1'b0;
    next_cyc(); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next_cyc(); load_hit(5'd6);
    end
    for (int i = 0; i < 2; i++) begin
      next_cyc(); branch_taken_ex = 1'b1;
    end
    next_cyc(); md_op_ex = 1'b1;
    next_cyc(); md_op_ex = 1'b1;
    next_cyc(); md_op_ex = 1'b1;
    next_cyc(); md_op_ex = 1'b1; md_done = 1'b1;
    next_cyc(); #1;
    check("cnt_load", load_stall_cnt, 32'd3);
    check("cnt_flush", flush_cnt, 32'd2);
    check("cnt_md", md_stall_cnt, 32'd3);

    next_cyc(); rst_n = 1'b0; #1;
    check("cnt_reset", load_stall_cnt, 32'd0);
    next_cyc(); rst_n = 1'b1;
    for (int i = 0; i < 17; i++) begin
      next_cyc(); load_hit(5'd8);
    end
    next_cyc(); #1;
    check("cnt_load_17", load_stall_cnt, 32'd17);
    check("cnt4_wrap", {28'd0, load_stall_cnt4}, 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the five-stage RISC-V core.
- Generates stall and flush controls for PC, IF/ID, ID/EX and EX/MEM.
- Handles three cases: load-use interlocks, taken-branch/jump flushes, and sequencing a multi-cycle mul/div unit through a start/done handshake.
- Works alongside the operand-forwarding unit, covering the hazards that forwarding cannot resolve.

Parameters:
- REG_ADDR_WIDTH, 5, register-address width.
- CNT_WIDTH, 32, width of performance counters (optional feature only).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- rs1_addr_id  in  REG_ADDR_WIDTH  rs1 of instruction in ID
- rs2_addr_id  in  REG_ADDR_WIDTH  rs2 of instruction in ID
- rs1_used_id  in  1  ID instruction reads rs1
- rs2_used_id  in  1  ID instruction reads rs2
- rd_addr_ex  in  REG_ADDR_WIDTH  destination of instruction in EX
- mem_read_ex  in  1  EX instruction is a load
- branch_taken_ex  in  1  EX resolves a taken branch/jump
- md_op_ex  in  1  EX instruction is mul/div
- md_done  in  1  mul/div result valid (single-cycle pulse)
- md_start  out  1  start pulse to mul/div unit
- md_busy  out  1  controller waiting on mul/div
- stall_pc  out  1  hold PC
- stall_if_id  out  1  hold IF/ID register
- stall_id_ex  out  1  hold ID/EX register
- flush_if_id  out  1  load bubble into IF/ID
- flush_id_ex  out  1  load bubble into ID/EX
- flush_ex_mem  out  1  load bubble into EX/MEM

Behaviour:
- Reset: state=RUN. All outputs 0 while rst_n=0, with no dependence on clk. Deasserting reset mid-handshake abandons the mul/div operation; md_start is not re-issued until md_op_ex is seen in RUN.
- FSM has two states, RUN and MD_WAIT. All outputs are combinational from state and inputs; there is no added latency.
- Load-use hazard, evaluated in RUN:
  - Condition: hit = mem_read_ex & (rd_addr_ex≠0) & ((rs1_used_id & rs1_addr_id==rd_addr_ex) | (rs2_used_id & rs2_addr_id==rd_addr_ex)).
  - Response: stall_pc=1, stall_if_id=1, flush_id_ex=1 for exactly one cycle, since the load leaves EX on the next edge.
- Branch, evaluated in RUN with branch_taken_ex=1:
  - flush_if_id=1, flush_id_ex=1, no stalls.
  - Has priority over load-use: the load-use stall is suppressed because the ID instruction is discarded.
- Mul/div:
  - RUN with md_op_ex=1: md_start=1 for one cycle; stall_pc, stall_if_id, stall_id_ex, md_busy=1; flush_ex_mem=1; next state MD_WAIT.
  - MD_WAIT with md_done=0: same stalls, md_busy=1, flush_ex_mem=1, md_start=0.
  - MD_WAIT with md_done=1: all stalls and flushes 0 so EX/MEM captures the result; md_busy=0; next state RUN.
  - md_done seen in RUN is ignored.
- Priority in RUN: branch_taken_ex > md_op_ex > load-use. mem_read_ex and md_op_ex are never both 1.
- In MD_WAIT, branch_taken_ex and load-use are ignored (EX holds the mul/div instruction).
- Back-to-back mul/div: the cycle after done is RUN; a new md_op_ex issues md_start immediately. Minimum per-op occupancy is 2 cycles.
- rd_addr_ex=0 never stalls.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined: adds output ports
  - load_stall_cnt, out, CNT_WIDTH: counts load-use stall cycles.
  - flush_cnt, out, CNT_WIDTH: counts branch flush cycles.
  - md_stall_cnt, out, CNT_WIDTH: counts cycles with md_busy=1.
  - All counters are cleared by rst_n, increment on clk rising edge, and wrap modulo 2^CNT_WIDTH.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Load-use: mem_read_ex=1, rd_addr_ex=5, rs2_addr_id=5, rs2_used_id=1 for one cycle -> stall_pc=stall_if_id=flush_id_ex=1 that cycle only; with rs2_used_id=0 -> all 0; with rd_addr_ex=0, rs1=0 -> all 0.
- Branch+load-use same cycle: branch_taken_ex=1 plus load-use hit on x7 -> flush_if_id=flush_id_ex=1, stall_pc=0, stall_if_id=0.
- Mul/div 4-cycle: md_op_ex=1 at cycle 0, md_done=1 at cycle 3 -> md_start=1 at cycle 0 only; stalls and flush_ex_mem=1 on cycles 0–2; all 0 on cycle 3; state RUN on cycle 4.
- Back-to-back: second md_op_ex=1 at cycle 4 -> md_start=1 at cycle 4; md_done during RUN with md_op_ex=0 -> no effect.
- Reset mid-op: rst_n=0 at cycle 2 of MD_WAIT -> all outputs 0 immediately; after release with md_op_ex=0 -> RUN, no stalls.
- HAZARD_PERF_CNT_EN: 3 load-use hits, 2 branches, one 4-cycle div -> load_stall_cnt=3, flush_cnt=2, md_stall_cnt=3; CNT_WIDTH=4 with 17 load hits -> load_stall_cnt=1.
